// File: rtl/fft16_sequencer.sv
// fft16_sequencer: 16-point radix-4 FFT sequencer. Collects 16 complex
// samples and runs two passes of four cycles each through an external
// combinational 4-point butterfly, applying Q1.15 twiddles between the
// passes. The spectrum is then streamed out with valid/ready.
// Optional build macro FFT16_SCALE_EN: every butterfly result is shifted
// right by 2 (1/16 overall gain). Without it, sums wrap modulo 2^16.
module fft16_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_r,
    input  logic signed [15:0] in_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_r,
    output logic signed [15:0] out_i,
    output logic               out_last,
    output logic               busy,
    output logic [63:0]        bf_in_r,
    output logic [63:0]        bf_in_i,
    input  logic [63:0]        bf_out_r,
    input  logic [63:0]        bf_out_i
);

    typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, UNLOAD} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic signed [15:0] buf_r [16];
    logic signed [15:0] buf_i [16];

    // Per-lane buffer address (shared by operand read and result writeback)
    logic [3:0]         addr [4];
    logic signed [15:0] wb_r [4];
    logic signed [15:0] wb_i [4];

    // W16^k real part in Q1.15; k = 0 is never used (multiply bypassed)
    function automatic logic signed [15:0] rom_cos(input logic [3:0] idx);
        case (idx)
            4'd1:    return 16'sd30274;
            4'd2:    return 16'sd23170;
            4'd3:    return 16'sd12540;
            4'd4:    return 16'sd0;
            4'd5:    return -16'sd12540;
            4'd6:    return -16'sd23170;
            4'd7:    return -16'sd30274;
            4'd8:    return 16'h8000;
            4'd9:    return -16'sd30274;
            default: return 16'sd0;
        endcase
    endfunction

    // W16^k imaginary part (-sin) in Q1.15
    function automatic logic signed [15:0] rom_nsin(input logic [3:0] idx);
        case (idx)
            4'd1:    return -16'sd12540;
            4'd2:    return -16'sd23170;
            4'd3:    return -16'sd30274;
            4'd4:    return 16'h8000;
            4'd5:    return -16'sd30274;
            4'd6:    return -16'sd23170;
            4'd7:    return -16'sd12540;
            4'd8:    return 16'sd0;
            4'd9:    return 16'sd12540;
            default: return 16'sd0;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic signed [15:0] bo_r, bo_i, res_r, res_i, cw, sw;
            logic [3:0]         tw_idx;
            logic signed [33:0] prod_r, prod_i;

            // Pass 1 walks columns (j + 4m), pass 2 walks rows (4g + m)
            assign addr[gi] = (state_reg == STAGE2) ? {cnt_reg[1:0], LANE}
                                                    : {LANE, cnt_reg[1:0]};
            assign bf_in_r[16*gi +: 16] = busy ? buf_r[addr[gi]] : 16'sd0;
            assign bf_in_i[16*gi +: 16] = busy ? buf_i[addr[gi]] : 16'sd0;

            assign bo_r = bf_out_r[16*gi +: 16];
            assign bo_i = bf_out_i[16*gi +: 16];
`ifdef FFT16_SCALE_EN
            assign res_r = bo_r >>> 2;
            assign res_i = bo_i >>> 2;
`else
            assign res_r = bo_r;
            assign res_i = bo_i;
`endif
            // Twiddle exponent j*m; zero means unity gain, so skip the multiply
            assign tw_idx = {2'b00, cnt_reg[1:0]} * {2'b00, LANE};
            assign cw     = rom_cos(tw_idx);
            assign sw     = rom_nsin(tw_idx);
            assign prod_r = 34'(res_r) * 34'(cw) - 34'(res_i) * 34'(sw) + 34'sd16384;
            assign prod_i = 34'(res_r) * 34'(sw) + 34'(res_i) * 34'(cw) + 34'sd16384;

            assign wb_r[gi] = (state_reg == STAGE1 && tw_idx != 4'd0) ? 16'(prod_r >>> 15) : res_r;
            assign wb_i[gi] = (state_reg == STAGE1 && tw_idx != 4'd0) ? 16'(prod_i >>> 15) : res_i;
        end
    endgenerate

    // State and counter registers; reset abandons any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter and handshake outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) state_next = STAGE1;
                end
            end
            STAGE1: begin
                busy     = 1'b1;
                cnt_next = (cnt_reg == 4'd3) ? 4'd0 : cnt_reg + 4'd1;
                if (cnt_reg == 4'd3) state_next = STAGE2;
            end
            STAGE2: begin
                busy     = 1'b1;
                cnt_next = (cnt_reg == 4'd3) ? 4'd0 : cnt_reg + 4'd1;
                if (cnt_reg == 4'd3) state_next = UNLOAD;
            end
            default: begin
                out_valid = 1'b1;
                out_last  = (cnt_reg == 4'd15);
                if (out_ready) begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) state_next = LOAD;
                end
            end
        endcase
    end

    // Sample buffer: input capture in LOAD, in-place butterfly writeback otherwise
    always_ff @(posedge clk) begin
        if (state_reg == LOAD && in_valid) begin
            buf_r[cnt_reg] <= in_r;
            buf_i[cnt_reg] <= in_i;
        end else if (busy) begin
            for (int m = 0; m < 4; m++) begin
                buf_r[addr[m]] <= wb_r[m];
                buf_i[addr[m]] <= wb_i[m];
            end
        end
    end

    // Output k comes from digit-reversed location 4*(k mod 4) + k/4
    assign out_r = out_valid ? buf_r[{cnt_reg[1:0], cnt_reg[3:2]}] : 16'sd0;
    assign out_i = out_valid ? buf_i[{cnt_reg[1:0], cnt_reg[3:2]}] : 16'sd0;

endmodule

// File: tb/tb_fft16_sequencer.sv
// Testbench for fft16_sequencer: scoreboard of expected spectra produced by
// a floating-point 16-point DFT (or exact constants for directed frames),
// with a separate monitor comparing every presented output sample.
module tb_fft16_sequencer;

`ifdef FFT16_SCALE_EN
    localparam int IMP = 62, DC0 = 100, TOL_X1 = 2, TOL_RND = 3;
`else
    localparam int IMP = 1000, DC0 = 1600, TOL_X1 = 1, TOL_RND = 4;
`endif
    localparam real PI = 3.14159265358979;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready;
    logic signed [15:0] in_r, in_i;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_r, out_i;
    logic               out_last, busy;
    logic [63:0]        bf_in_r, bf_in_i, bf_out_r, bf_out_i;

    fft16_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_last(out_last), .busy(busy),
        .bf_in_r(bf_in_r), .bf_in_i(bf_in_i), .bf_out_r(bf_out_r), .bf_out_i(bf_out_i)
    );

    always #5 clk = ~clk;

    // External butterfly: forward 4-point DFT, y[m] = sum x[n] * (-j)^(n*m), 16-bit wrap
    function automatic logic [127:0] bfly(input logic [63:0] ar, input logic [63:0] ai);
        logic [63:0] yr, yi;
        int xr, xi, sr, si;
        yr = '0;
        yi = '0;
        for (int m = 0; m < 4; m++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                xr = int'($signed(ar[16*n +: 16]));
                xi = int'($signed(ai[16*n +: 16]));
                case ((n * m) % 4)
                    0: begin sr += xr; si += xi; end
                    1: begin sr += xi; si -= xr; end
                    2: begin sr -= xr; si -= xi; end
                    default: begin sr -= xi; si += xr; end
                endcase
            end
            yr[16*m +: 16] = 16'(sr);
            yi[16*m +: 16] = 16'(si);
        end
        return {yi, yr};
    endfunction

    assign {bf_out_i, bf_out_r} = bfly(bf_in_r, bf_in_i);

    typedef struct {
        int r;
        int i;
        int tol;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mode = 0;          // out_ready pattern: 0 always, 1 random, 2 toggle
    int   fr[16], fi[16];
    int   er[16], ei[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    // Reference: direct DFT X[k] = sum x[n] e^{-j 2 pi n k / 16}
    task automatic push_model(input int tol);
        real sr, si, th;
        for (int k = 0; k < 16; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 16; n++) begin
                th = 2.0 * PI * real'(n * k) / 16.0;
                sr += real'(fr[n]) * $cos(th) + real'(fi[n]) * $sin(th);
                si += real'(fi[n]) * $cos(th) - real'(fr[n]) * $sin(th);
            end
`ifdef FFT16_SCALE_EN
            sr = sr / 16.0;
            si = si / 16.0;
`endif
            er[k] = $rtoi(sr + ((sr >= 0.0) ? 0.5 : -0.5));
            ei[k] = $rtoi(si + ((si >= 0.0) ? 0.5 : -0.5));
            sbq.push_back('{r: er[k], i: ei[k], tol: tol, last: (k == 15)});
        end
    endtask

    task automatic push_const(input int x0r, input int xor_other);
        for (int k = 0; k < 16; k++)
            sbq.push_back('{r: (k == 0) ? x0r : xor_other, i: 0, tol: 0, last: (k == 15)});
    endtask

    task automatic fill_random();
        for (int n = 0; n < 16; n++) begin
            fr[n] = int'($urandom_range(2000)) - 1000;
            fi[n] = int'($urandom_range(2000)) - 1000;
        end
    endtask

    task automatic fill_const(input int v0, input int vrest, input int pos);
        for (int n = 0; n < 16; n++) begin
            fr[n] = (n == pos) ? v0 : vrest;
            fi[n] = 0;
        end
    endtask

    // Drive one frame with random idle gaps; optionally keep in_valid high until the frame drains
    task automatic drive_frame(input bit hold);
        bit hs;
        bit done;
        int w;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                in_r = 16'($urandom);
                in_i = 16'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_r = 16'(fr[n]);
            in_i = 16'(fi[n]);
            hs = 1'b0;
            w = 0;
            while (!hs && w < 300) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
                w++;
            end
            chk("in_handshake", int'(hs), 1, 0);
        end
        if (hold) begin
            done = 1'b0;
            w = 0;
            while (!done && w < 300) begin
                in_r = 16'($urandom);
                in_i = 16'($urandom);
                @(negedge clk);
                done = out_valid && out_last && out_ready;
                @(posedge clk); #1;
                w++;
            end
            chk("hold_release", int'(done), 1, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sbq.size() != 0 && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain", sbq.size(), 0, 0);
    endtask

    // Out-ready pattern generator
    always begin
        @(posedge clk); #1;
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(1));
            default: out_ready = !out_ready;
        endcase
    end

    // Monitor: compares presented outputs against the scoreboard head
    int  in_cnt = 0;
    int  last_in_cyc = 0;
    int  xfer = 0;
    bit  expect_first = 0;
    bit  expect_rdy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_cnt = 0;
            xfer = 0;
            expect_first = 0;
            expect_rdy = 0;
        end else begin
            if (expect_rdy) begin
                chk("in_ready_after_last", int'(in_ready), 1, 0);
                expect_rdy = 0;
            end
            if (busy || out_valid) chk("in_ready_low", int'(in_ready), 0, 0);
            if (!busy) chk("bf_in_idle_zero", int'(|{bf_in_r, bf_in_i}), 0, 0);
            if (in_valid && in_ready) begin
                in_cnt++;
                if (in_cnt == 16) begin
                    in_cnt = 0;
                    last_in_cyc = cyc;
                    expect_first = 1;
                end
            end
            if (out_valid) begin
                if (expect_first) begin
                    chk("first_out_latency", cyc - last_in_cyc, 9, 0);
                    expect_first = 0;
                end
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0, 0);
                end else begin
                    e = sbq[0];
                    chk("out_r", int'(out_r), e.r, e.tol);
                    chk("out_i", int'(out_i), e.i, e.tol);
                    chk("out_last", int'(out_last), int'(e.last), 0);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        xfer++;
                        $display("xfer %0d: out=(%0d,%0d) exp=(%0d,%0d) last=%0d",
                                 xfer - 1, out_r, out_i, e.r, e.i, out_last);
                        if (e.last) begin
                            chk("xfers_per_frame", xfer, 16, 0);
                            xfer = 0;
                            expect_rdy = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        #12;
        chk("reset_in_ready", int'(in_ready), 1, 0);
        chk("reset_out_valid", int'(out_valid), 0, 0);
        chk("reset_out_last", int'(out_last), 0, 0);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_bf_in", int'(|{bf_in_r, bf_in_i}), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Impulse, DC and single-tone directed frames
        mode = 0;
        fill_const(1000, 0, 0);
        push_const(IMP, IMP);
        drive_frame(0);
        fill_const(100, 100, 0);
        push_const(DC0, 0);
        drive_frame(0);
        fill_const(1000, 0, 1);
        push_model(TOL_X1);
        drive_frame(0);
        wait_drain();

        // Random frames with random downstream backpressure
        mode = 1;
        for (int f = 0; f < 6; f++) begin
            fill_random();
            push_model(TOL_RND);
            drive_frame(0);
        end
        wait_drain();

        // Strict 1,0,1,0 out_ready toggling
        mode = 2;
        fill_random();
        push_model(TOL_RND);
        drive_frame(0);
        wait_drain();

        // Reset in the middle of the first butterfly pass, then a fresh impulse
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        fill_random();
        drive_frame(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_in_stage1", int'(busy), 1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_in_ready", int'(in_ready), 1, 0);
        chk("midrst_out_valid", int'(out_valid), 0, 0);
        chk("midrst_bf_in", int'(|{bf_in_r, bf_in_i}), 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_const(1000, 0, 0);
        push_const(IMP, IMP);
        drive_frame(0);
        wait_drain();

        // in_valid held high with junk through processing and unload
        mode = 1;
        fill_random();
        push_model(TOL_RND);
        drive_frame(1);
        fill_random();
        push_model(TOL_RND);
        drive_frame(0);
        wait_drain();

        repeat (3) @(posedge clk);
        chk("queue_empty", sbq.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
